// File: rtl/mm_arbiter2.sv
// mm_arbiter2 -- two-master, one-slave Avalon-MM arbiter with pipelined reads.
//
// Shares one slave between m0 (JTAG MM bridge) and m1 (core data port).
// A transfer is granted round-robin, then the owner's request is muxed
// straight to the slave until the slave accepts it. Each accepted read
// pushes the owner's id into an in-order tag FIFO, and returning
// s_readdatavalid beats are steered to the master at the FIFO head.
//
// Ports:
//   clk_clk, reset_reset_n         clock, asynchronous active-low reset
//   mN_address/read/write/
//   mN_writedata/byteenable        master N request (held until accepted)
//   mN_waitrequest                 master N stall
//   mN_readdata/readdatavalid      read return (data broadcast to both)
//   s_*                            slave-side Avalon-MM interface
//   err_orphan                     sticky: read data arrived with no tag
//   timeout_err                    sticky: a grant timed out (macro only)
//
// Optional feature macro: MM_ARB_TIMEOUT_EN
//   Abandons a grant after TIMEOUT stalled cycles; an abandoned read is
//   answered later with a synthetic 32'hDEADBEEF beat.
module mm_arbiter2 #(
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [31:0]   m0_writedata,
  input  logic [3:0]    m0_byteenable,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [31:0]   m1_writedata,
  input  logic [3:0]    m1_byteenable,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,
  output logic [AW-1:0] s_address,
  output logic          s_read,
  output logic          s_write,
  output logic [31:0]   s_writedata,
  output logic [3:0]    s_byteenable,
  input  logic          s_waitrequest,
  input  logic [31:0]   s_readdata,
  input  logic          s_readdatavalid,
  output logic          err_orphan
`ifdef MM_ARB_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int unsigned PW = $clog2(MAX_PEND);
  localparam int unsigned CW = $clog2(MAX_PEND + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic          owner_q;
  logic          last_q;
  logic          err_orphan_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          tag_id_q [MAX_PEND];

  logic          fifo_full, fifo_empty;
  logic          req0, req1;
  logic          in_grant;
  logic          own_wr, own_rd;
  logic          tmo_hit;
  logic          done, accept;
  logic          owner_wait;
  logic          push, pop, pop_syn, orphan;
  logic          head_id, head_syn;

  assign fifo_full  = (count_q == CW'(MAX_PEND));
  assign fifo_empty = (count_q == '0);

  // A read can only be granted while there is room to tag it.
  assign req0 = m0_write | (m0_read & ~fifo_full);
  assign req1 = m1_write | (m1_read & ~fifo_full);

  assign in_grant = (state_q == GRANT);

  // Write wins when a master asserts both strobes.
  assign own_wr = owner_q ? m1_write : m0_write;
  assign own_rd = (owner_q ? m1_read : m0_read) & ~own_wr;

`ifdef MM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_err_q;
  logic          tag_syn_q [MAX_PEND];

  assign tmo_hit     = in_grant & (tmo_cnt_q == TW'(TIMEOUT));
  assign head_syn    = tag_syn_q[rd_ptr_q];
  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign head_syn = 1'b0;
`endif

  assign s_address    = owner_q ? m1_address    : m0_address;
  assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
  assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
  assign s_read       = in_grant & own_rd & ~tmo_hit;
  assign s_write      = in_grant & own_wr & ~tmo_hit;

  // A timeout ends the grant even if the slave happens to accept in the
  // same cycle: the strobes are already forced low, so the slave saw nothing.
  assign accept     = in_grant & ~s_waitrequest & ~tmo_hit;
  assign done       = in_grant & (~s_waitrequest | tmo_hit);
  assign owner_wait = s_waitrequest & ~tmo_hit;

  assign m0_waitrequest = (in_grant & ~owner_q) ? owner_wait : 1'b1;
  assign m1_waitrequest = (in_grant &  owner_q) ? owner_wait : 1'b1;

  // Tag FIFO. Synthetic entries pop only on cycles with no real beat; a
  // real beat arriving while a synthetic entry is at the head is an orphan.
  assign head_id = tag_id_q[rd_ptr_q];
  assign push    = done & own_rd;
  assign pop_syn = ~s_readdatavalid & ~fifo_empty & head_syn;
  assign pop     = (s_readdatavalid & ~fifo_empty & ~head_syn) | pop_syn;
  assign orphan  = s_readdatavalid & (fifo_empty | head_syn);

  assign m0_readdatavalid = pop & ~head_id;
  assign m1_readdatavalid = pop &  head_id;
  assign m0_readdata      = pop_syn ? 32'hDEAD_BEEF : s_readdata;
  assign m1_readdata      = pop_syn ? 32'hDEAD_BEEF : s_readdata;
  assign err_orphan       = err_orphan_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      tag_id_q[wr_ptr_q]  <= owner_q;
`ifdef MM_ARB_TIMEOUT_EN
      tag_syn_q[wr_ptr_q] <= tmo_hit;
`endif
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      err_orphan_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
`ifdef MM_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q <= GRANT;
            owner_q <= (req0 && req1) ? ~last_q : req1;
`ifdef MM_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        GRANT: begin
          if (done) begin
            state_q <= IDLE;
            if (accept) last_q <= owner_q;
          end
`ifdef MM_ARB_TIMEOUT_EN
          if (tmo_hit) timeout_err_q <= 1'b1;
          else if (s_waitrequest) tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
        end
        default: state_q <= IDLE;
      endcase

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_arbiter2.sv
// Randomized scoreboard bench for mm_arbiter2 (default build).
// A driver plays two Avalon masters and a slave with random stall and
// read latency; a separate monitor predicts each arbitration from the
// round-robin rule and FIFO occupancy, and checks transfers and returns.
module tb_mm_arbiter2;
  localparam int AW = 32;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } txn_t;

  typedef struct {
    logic [31:0] d;
    int unsigned due;
  } ret_t;

  txn_t cur [2];
  bit   act [2];
  bit   done [2];
  txn_t iss0 [$];
  txn_t iss1 [$];
  ret_t sq [$];

  logic          m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0]   m0_readdata, m1_readdata;
  logic [AW-1:0] s_address;
  logic          s_read, s_write;
  logic [31:0]   s_writedata;
  logic [3:0]    s_byteenable;
  logic          s_waitrequest, s_readdatavalid;
  logic [31:0]   s_readdata;
  logic          err_orphan;
`ifdef MM_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  mm_arbiter2 #(.AW(AW), .MAX_PEND(MP), .TIMEOUT(255)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .m0_address       (cur[0].addr),
    .m0_read          (cur[0].rd),
    .m0_write         (cur[0].wr),
    .m0_writedata     (cur[0].data),
    .m0_byteenable    (cur[0].be),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (cur[1].addr),
    .m1_read          (cur[1].rd),
    .m1_write         (cur[1].wr),
    .m1_writedata     (cur[1].data),
    .m1_byteenable    (cur[1].be),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .err_orphan       (err_orphan)
`ifdef MM_ARB_TIMEOUT_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act_v, exp_v, $time);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  int tagq [$];
  int cntm;
  bit lastm;
  bit decide;
  int exp_g;
  bit orph_m;
  bit mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    bit   sacc, e0, e1;
    int   g, low, e;
    txn_t t;
    if (mon_en) begin
      sacc = (s_read || s_write) && !s_waitrequest;
      low  = int'(!m0_waitrequest) + int'(!m1_waitrequest);
      chk("single_owner_ack", 32'(low), sacc ? 32'd1 : 32'd0);
      chk("err_orphan", 32'(err_orphan), 32'(orph_m));

      if (decide) begin
        // Cycle after reset or after an accepted transfer: arbitration cycle.
        chk("idle_outputs", 32'({s_read, s_write, m0_waitrequest, m1_waitrequest}), 32'h3);
        e0 = act[0] && (cur[0].wr || cntm < MP);
        e1 = act[1] && (cur[1].wr || cntm < MP);
        if (e0 || e1) begin
          exp_g  = (e0 && e1) ? int'(!lastm) : (e1 ? 1 : 0);
          decide = 1'b0;
        end
      end else if (sacc) begin
        g = m0_waitrequest ? 1 : 0;
        chk("grant_order", 32'(g), 32'(exp_g));
        if ((g == 0 ? iss0.size() : iss1.size()) == 0) begin
          chk("txn_outstanding", 32'd0, 32'd1);
        end else begin
          t = (g == 0) ? iss0.pop_front() : iss1.pop_front();
          chk("s_address", s_address, t.addr);
          chk("s_writedata", s_writedata, t.data);
          chk("s_byteenable", 32'(s_byteenable), 32'(t.be));
          chk("s_write", 32'(s_write), 32'(t.wr));
          chk("s_read", 32'(s_read), 32'(t.rd && !t.wr));
          if (t.rd && !t.wr) begin
            tagq.push_back(g);
            cntm++;
          end
        end
        lastm  = g[0];
        decide = 1'b1;
        chk("fifo_bound", 32'(cntm <= MP), 32'd1);
      end

      if (s_readdatavalid) begin
        if (tagq.size() == 0) begin
          chk("orphan_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
          orph_m = 1'b1;
        end else begin
          e = tagq.pop_front();
          cntm--;
          chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(e == 0));
          chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(e == 1));
          chk("m0_readdata", m0_readdata, s_readdata);
          chk("m1_readdata", m1_readdata, s_readdata);
        end
      end else begin
        chk("rdv_quiet", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  int unsigned cyc = 0;
  int req_p, sw_p, ret_p, lat_lo, lat_hi;
  bit gen_en;

  task automatic start_txn(input int n, input txn_t t);
    cur[n] = t;
    act[n] = 1'b1;
    if (n == 0) iss0.push_back(t);
    else        iss1.push_back(t);
  endtask

  task automatic rand_txn(input int n);
    txn_t t;
    int   k;
    k      = $urandom_range(0, 7);
    t.rd   = (k < 4) || (k == 7);
    t.wr   = (k >= 4);
    t.addr = $urandom;
    t.data = $urandom;
    t.be   = 4'($urandom);
    start_txn(n, t);
  endtask

  task automatic sample();
    @(negedge clk);
    done[0] = act[0] && !m0_waitrequest;
    done[1] = act[1] && !m1_waitrequest;
    if (s_read && !s_waitrequest)
      sq.push_back('{d: $urandom, due: cyc + $urandom_range(lat_lo, lat_hi)});
  endtask

  task automatic drive();
    ret_t r;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        act[n]  = 1'b0;
        cur[n]  = '0;
        done[n] = 1'b0;
      end
      if (!act[n] && gen_en && $urandom_range(0, 99) < req_p) rand_txn(n);
    end
    s_waitrequest = ($urandom_range(0, 99) < sw_p);
    if (sq.size() > 0 && sq[0].due <= cyc && $urandom_range(0, 99) < ret_p) begin
      r = sq.pop_front();
      s_readdatavalid = 1'b1;
      s_readdata      = r.d;
    end else begin
      s_readdatavalid = 1'b0;
      s_readdata      = $urandom;
    end
  endtask

  task automatic run_phase(input int ncyc, input int rq, input int sw, input int rt,
                           input int llo, input int lhi);
    req_p = rq; sw_p = sw; ret_p = rt; lat_lo = llo; lat_hi = lhi;
    for (int i = 0; i < ncyc; i++) begin
      sample();
      drive();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    txn_t t;
    int   i;
    rst_n = 1'b0;
    cur[0] = '0; cur[1] = '0;
    act[0] = 1'b0; act[1] = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    gen_en = 1'b0;
    req_p = 0; sw_p = 0; ret_p = 100; lat_lo = 1; lat_hi = 3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_read", 32'(s_read), 32'd0);
    chk("rst_s_write", 32'(s_write), 32'd0);
    chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);

    tagq.delete(); cntm = 0; lastm = 1'b1; decide = 1'b1; orph_m = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single uncontended write: s_write for exactly one cycle, the second one.
    t.rd = 1'b0; t.wr = 1'b1; t.addr = 32'h4; t.data = 32'h1234_5678; t.be = 4'hF;
    start_txn(0, t);
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk("single_s_write", 32'(s_write), 32'(c == 2));
      chk("single_m0_waitrequest", 32'(m0_waitrequest), 32'(c != 2));
      chk("single_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
      drive();
    end

    gen_en = 1'b1;
    run_phase(1500, 60, 30, 75, 1, 4);   // mixed traffic, quick returns
    run_phase(1500, 70, 20, 15, 3, 10);  // slow returns keep the FIFO full
    run_phase(600, 100, 0, 90, 1, 3);    // constant contention, no stalls

    gen_en = 1'b0;
    sw_p = 20; ret_p = 100;
    for (i = 0; i < 3000 && (act[0] || act[1] || sq.size() > 0); i++) begin
      sample();
      drive();
    end
    chk("drain_in_time", 32'(i < 3000), 32'd1);
    sample();
    chk("tags_drained", 32'(tagq.size()), 32'd0);
    drive();

    // Read data with nothing outstanding sets the sticky orphan flag.
    s_readdatavalid = 1'b1;
    s_readdata      = 32'h0000_0BAD;
    @(posedge clk);
    #1;
    s_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_orphan_held", 32'(err_orphan), 32'd1);

    // Reset in the middle of a stalled grant drops the strobes immediately.
    @(posedge clk);
    #1;
    s_waitrequest = 1'b1;
    t.rd = 1'b0; t.wr = 1'b1; t.addr = 32'h40; t.data = 32'hCAFE_F00D; t.be = 4'h3;
    start_txn(0, t);
    repeat (3) @(negedge clk);
    chk("midgrant_s_write", 32'(s_write), 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_write", 32'(s_write), 32'd0);
    chk("async_rst_s_read", 32'(s_read), 32'd0);
    chk("async_rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    chk("async_rst_err_orphan", 32'(err_orphan), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mm_arbiter2.md
Name: mm_arbiter2

Overview:
- Two-master, one-slave Avalon-MM arbiter with pipelined-read support.
- Lets the JTAG MM bridge (m0) and the RISC-V core data port (m1) share the memory-mapped register bank on the FPGA top level.
- Round-robin grant per transfer.
- Routes slave readdatavalid back to the issuing master through an in-order tag FIFO.

Parameters:
- AW, 32, address width for both masters and the slave.
- MAX_PEND, 4, maximum outstanding reads (tag FIFO depth, power of 2, ≥2).
- TIMEOUT, 255, waitrequest timeout in cycles; only used with MM_ARB_TIMEOUT_EN.

Ports:
- clk_clk  in  1  system clock; all state on rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- mN_address  in  AW  master N address (N=0,1).
- mN_read, mN_write  in  1  master N request strobes, held until waitrequest low.
- mN_writedata  in  32  master N write data.
- mN_byteenable  in  4  master N byte enables.
- mN_waitrequest  out  1  master N stall.
- mN_readdata  out  32  = s_readdata, broadcast to both masters.
- mN_readdatavalid  out  1  read data for master N.
- s_address  out  AW  slave address.
- s_read, s_write  out  1  slave strobes.
- s_writedata  out  32  slave write data.
- s_byteenable  out  4  slave byte enables.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- s_readdatavalid  in  1  slave read data valid.
- err_orphan  out  1  sticky: readdatavalid arrived with no outstanding tag.

Behaviour:
- Reset (async, reset_reset_n=0):
  - state=IDLE, owner=0, last=1 (m0 wins first tie).
  - FIFO empty, err_orphan=0.
  - All s_read/s_write/mN_readdatavalid = 0; all mN_waitrequest = 1.
- Request eligibility: reqN = mN_write | (mN_read & ~fifo_full).
  - A read with the FIFO full stays waiting; a write is always eligible.
- IDLE:
  - No requests: stay in IDLE.
  - One eligible request: owner <= that master; go to GRANT.
  - Both eligible: owner <= ~last; go to GRANT.
  - Both mN_waitrequest = 1; s_read = s_write = 0.
- GRANT:
  - s_address/s_writedata/s_byteenable/s_read/s_write = owner's inputs, combinational mux.
  - m[owner]_waitrequest = s_waitrequest; the non-owner sees 1.
  - On the cycle s_waitrequest=0 (transfer accepted):
    - last <= owner; go to IDLE.
    - If it is a read, push {owner} into the tag FIFO.
  - Minimum 2 cycles per transfer; at most one transfer per arbitration.
- Master asserting both read and write: write takes priority; read is ignored for that transfer.
- Read return:
  - s_readdatavalid=1 with FIFO non-empty: pop, and drive m[head]_readdatavalid=1 in the same cycle, combinational.
  - s_readdatavalid=1 with FIFO empty: ignored; err_orphan <= 1 and holds until reset.
  - Push and pop in the same cycle: count unchanged; data order preserved.
- FIFO count range is 0..MAX_PEND.
  - fifo_full = (count == MAX_PEND).
  - Pointers wrap modulo MAX_PEND.
- Owner deasserting its strobe mid-GRANT is a protocol violation and is not handled.
- Reset asserted mid-transfer: immediately returns to reset values; outstanding tags are discarded.

Optional Feature:
- Macro: MM_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to GRANT and increments each GRANT cycle with s_waitrequest=1.
  - When the counter reaches TIMEOUT, that cycle:
    - s_read/s_write are forced to 0 and m[owner]_waitrequest=0.
    - Go to IDLE.
    - Sticky output timeout_err (1 bit, reset 0) <= 1.
    - If the transfer was a read, push {owner, synth=1} into the FIFO.
  - A synth entry at the FIFO head:
    - Pops on the next cycle with s_readdatavalid=0.
    - In that cycle drives m[id]_readdatavalid=1 and mN_readdata=32'hDEADBEEF.
    - If s_readdatavalid=1 while the head is synth, the slave beat is treated as orphan.
- Disabled: no counter, no timeout_err port; GRANT waits indefinitely and FIFO entries carry no synth bit.

Test Plan:
- Single write, no contention:
  - Stimulus: m0 writes 0x12345678 to addr 0x4, be=0xF; slave waitrequest=0.
  - Response: s_write high exactly 1 cycle at cycle 2; m0_waitrequest low that cycle; m1_waitrequest constantly 1.
- Contention:
  - Stimulus: m0 and m1 assert writes in the same cycle after reset, held for 3 transfers each.
  - Response: grant order m0, m1, m0, m1, m0, m1; each transfer takes 2 cycles.
- Pipelined reads, out-of-master order:
  - Stimulus: m1 reads, then m0 reads, then m1 reads; slave returns 0xA, 0xB, 0xC with latency 3.
  - Response: m1_readdatavalid with 0xA, m0 with 0xB, m1 with 0xC, in order.
- FIFO full:
  - Stimulus: MAX_PEND=4; issue 4 reads with no return; m0 then requests a 5th read while m1 requests a write.
  - Response: m1 write granted; m0 read stalls until one readdatavalid pops, then is granted.
- Orphan and reset:
  - Stimulus: s_readdatavalid pulse with an empty FIFO.
  - Response: err_orphan=1 and held.
  - Stimulus: reset_reset_n low mid-GRANT.
  - Response: s_read/s_write drop asynchronously; err_orphan=0.
- Timeout (MM_ARB_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: m0 read with slave waitrequest stuck at 1.
  - Response: m0_waitrequest low on GRANT cycle 9; next cycle m0_readdatavalid with 0xDEADBEEF; timeout_err=1.
